div_seq_ctrl: RTL
=================

// Module: div_seq_ctrl
// PURPOSE
//   Multi-cycle sequencer for the DIV/MOD/DIVU/MODU ALU operations in the EX stage.
//   - Accepts one divide request and stalls the pipeline while it runs.
//   - Runs a radix-2 restoring iteration: one quotient bit per cycle.
//   - Applies sign fix-up, then presents a one-cycle done with the result.
//   - Sits beside the single-cycle ALU. EX muxes its result in when aluctrl is in {ALU_DIV..ALU_MODU}.
// PARAMETERS
//   DATA_W   32   operand/result width; the iteration count equals DATA_W
//   CNT_W    $clog2(DATA_W)   iteration counter width (derived, do not override)
// PORTS
//   clk      in   1        core clock
//   reset    in   1        synchronous, active-high reset
//   start    in   1        EX holds a divide op with valid operands
//   op       in   2        00 DIV, 01 MOD, 10 DIVU, 11 MODU
//   src1     in   DATA_W   dividend (rj)
//   src2     in   DATA_W   divisor (rk)
//   flush    in   1        pipeline flush; abort any operation in flight
//   stall    out  1        hold IF/ID/EX this cycle
//   done     out  1        result valid this cycle (one-cycle pulse)
//   result   out  DATA_W   quotient (DIV/DIVU) or remainder (MOD/MODU)
// BEHAVIOUR
//   Reset and flush
//   - reset (synchronous) => state IDLE, counter 0, done 0, result 0.
//   - stall is combinational and reads 0 while reset is high.
//   - flush in any state => IDLE next cycle and done is not raised. It has priority over start.
//   - flush in the DONE cycle does not suppress that cycle's done; EX discards the result.
//   - Reset or flush mid-operation discards all partial state.
//   State machine: IDLE, ITER, DONE
//   - IDLE:
//     - start=1 and src2!=0: latch |src1|, |src2| (magnitudes only for signed ops), the sign
//       flags and op; load counter DATA_W-1 => ITER.
//     - start=1 and src2==0: go directly to DONE. Quotient is all ones; remainder is src1.
//   - ITER:
//     - each cycle: shift the partial remainder left and bring in the next dividend bit.
//     - trial-subtract the divisor; keep the result and set the quotient bit when the
//       difference is non-negative.
//     - counter==0 => DONE, otherwise decrement the counter.
//   - DONE:
//     - done=1; result = sign-fixed quotient or remainder; next state IDLE.
//     - start is ignored in DONE because the same instruction is leaving EX.
//   Sign fix-up (signed ops only)
//   - quotient is negated when sign(src1) ^ sign(src2).
//   - remainder takes the sign of src1.
//   - -2^31 / -1 gives quotient 0x80000000 and remainder 0 (natural wrap, no trap).
//   stall
//   - = (IDLE & start & ~flush) | ITER.
//   - Low in DONE, so the instruction advances with result in the same cycle.
//   Latency and holding
//   - start in IDLE at cycle T gives ITER during T+1..T+DATA_W and done at T+DATA_W+1.
//   - The divide-by-zero path gives done at T+1.
//   - result holds its last value after done until the next DONE.
//   - Upstream keeps start, op, src1 and src2 stable while stall=1.
//     The block latches its operands, so later changes are don't-care.
// CONFIGURATION
//   DIV_OPCACHE_EN defined
//   - On every DONE, store src1, src2, the signedness, the fixed quotient and the fixed
//     remainder, and set cache_valid.
//   - start in IDLE with src1, src2 and signedness equal to the stored entry => DONE at T+1,
//     returning the stored quotient or remainder per op. stall is 0 in this case.
//   - reset clears cache_valid. flush does not touch the cache.
//   DIV_OPCACHE_EN not defined
//   - No cache storage; every non-zero-divisor request takes DATA_W+1 cycles.
// TESTING
//   1 DIV 100/7 with start at T
//     -> stall=1 over T..T+32, done=1 and result=14 at T+33, stall=0 at T+33.
//   2 DIV -7/2 -> 0xFFFFFFFD.  MOD -7/2 -> 0xFFFFFFFF.  DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
//   3 DIV 0x80000000/0xFFFFFFFF -> 0x80000000.  MOD with the same operands -> 0.
//   4 DIVU 5/0 -> 0xFFFFFFFF at T+1.  MODU 5/0 -> 5 at T+1.
//     DIV -3/0 -> 0xFFFFFFFF.  MOD -3/0 -> 0xFFFFFFFD.
//   5 flush at T+10 of DIV 100/7 -> no done pulse and IDLE at T+11.
//     A new start at T+11 (MODU 9/4) -> done at T+44 with result 1.
//   6 DIV 100/7, then MOD 100/7
//     -> with DIV_OPCACHE_EN: result 2 one cycle after start, stall=0.
//     -> without the macro: result 2 at start+33.
//     -> reset between the two ops forces the 33-cycle path in both builds.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle radix-2 restoring divide sequencer for DIV/MOD/DIVU/MODU in EX.
// Optional single-entry operand/result cache, enabled with `define DIV_OPCACHE_EN.
module div_seq_ctrl #(
   parameter  int DATA_W = 32,
   localparam int CNT_W  = $clog2(DATA_W)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] src1,
   input  logic [DATA_W-1:0] src2,
   input  logic              flush,
   output logic              stall,
   output logic              done,
   output logic [DATA_W-1:0] result
);

   // Handshake: a request is accepted when start=1 in IDLE without flush. stall holds the
   // pipeline while the request runs; done is a one-cycle pulse with result, and stall is
   // low in that cycle so the instruction leaves EX together with its result.
   typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [DATA_W-1:0]   rem_q;
   logic [DATA_W-1:0]   quo_q;
   logic [DATA_W-1:0]   dvs_q;
   logic                neg_quo;
   logic                neg_rem;
   logic                is_mod;
   logic                done_r;
   logic [DATA_W-1:0]   result_r;

   logic                signed_op;
   logic                s1_neg;
   logic                s2_neg;
   logic [DATA_W-1:0]   mag1;
   logic [DATA_W-1:0]   mag2;
   logic [DATA_W-1:0]   zero_res;
   logic                cache_hit;

   logic [DATA_W:0]     rem_sh;
   logic [DATA_W:0]     diff;
   logic                take;
   logic [DATA_W-1:0]   rem_nx;
   logic [DATA_W-1:0]   quo_nx;
   logic [DATA_W-1:0]   quo_fix;
   logic [DATA_W-1:0]   rem_fix;

   assign signed_op = ~op[1];
   assign s1_neg    = signed_op & src1[DATA_W-1];
   assign s2_neg    = signed_op & src2[DATA_W-1];
   assign mag1      = s1_neg ? -src1 : src1;
   assign mag2      = s2_neg ? -src2 : src2;
   assign zero_res  = op[0] ? src1 : '1;

   // quo_q starts as the dividend magnitude and is shifted out MSB-first into the
   // partial remainder while quotient bits enter at the LSB.
   assign rem_sh  = {rem_q, quo_q[DATA_W-1]};
   assign diff    = rem_sh - {1'b0, dvs_q};
   assign take    = ~diff[DATA_W];
   assign rem_nx  = take ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
   assign quo_nx  = {quo_q[DATA_W-2:0], take};
   assign quo_fix = neg_quo ? -quo_nx : quo_nx;
   assign rem_fix = neg_rem ? -rem_nx : rem_nx;

`ifdef DIV_OPCACHE_EN
   logic                c_valid;
   logic [DATA_W-1:0]   c_src1;
   logic [DATA_W-1:0]   c_src2;
   logic                c_sgn;
   logic [DATA_W-1:0]   c_quo;
   logic [DATA_W-1:0]   c_rem;
   logic [DATA_W-1:0]   o_src1;
   logic [DATA_W-1:0]   o_src2;
   logic                o_sgn;

   assign cache_hit = c_valid & (src1 == c_src1) & (src2 == c_src2) & (signed_op == c_sgn);
`else
   assign cache_hit = 1'b0;
`endif

   assign stall  = ~reset & (((state == S_IDLE) & start & ~flush & ~cache_hit) |
                             (state == S_ITER));
   assign done   = done_r;
   assign result = result_r;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         neg_quo  <= 1'b0;
         neg_rem  <= 1'b0;
         is_mod   <= 1'b0;
         done_r   <= 1'b0;
         result_r <= '0;
`ifdef DIV_OPCACHE_EN
         c_valid  <= 1'b0;
         c_src1   <= '0;
         c_src2   <= '0;
         c_sgn    <= 1'b0;
         c_quo    <= '0;
         c_rem    <= '0;
         o_src1   <= '0;
         o_src2   <= '0;
         o_sgn    <= 1'b0;
`endif
      end else begin
         done_r <= 1'b0;
         if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
            rem_q <= '0;
            quo_q <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     if (cache_hit) begin
`ifdef DIV_OPCACHE_EN
                        result_r <= op[0] ? c_rem : c_quo;
`endif
                        done_r   <= 1'b1;
                        state    <= S_DONE;
                     end else if (src2 == '0) begin
                        result_r <= zero_res;
                        done_r   <= 1'b1;
                        state    <= S_DONE;
`ifdef DIV_OPCACHE_EN
                        c_valid  <= 1'b1;
                        c_src1   <= src1;
                        c_src2   <= src2;
                        c_sgn    <= signed_op;
                        c_quo    <= '1;
                        c_rem    <= src1;
`endif
                     end else begin
                        rem_q   <= '0;
                        quo_q   <= mag1;
                        dvs_q   <= mag2;
                        neg_quo <= s1_neg ^ s2_neg;
                        neg_rem <= s1_neg;
                        is_mod  <= op[0];
                        cnt     <= CNT_W'(DATA_W - 1);
                        state   <= S_ITER;
`ifdef DIV_OPCACHE_EN
                        o_src1  <= src1;
                        o_src2  <= src2;
                        o_sgn   <= signed_op;
`endif
                     end
                  end
               end
               S_ITER: begin
                  rem_q <= rem_nx;
                  quo_q <= quo_nx;
                  if (cnt == '0) begin
                     result_r <= is_mod ? rem_fix : quo_fix;
                     done_r   <= 1'b1;
                     state    <= S_DONE;
`ifdef DIV_OPCACHE_EN
                     c_valid  <= 1'b1;
                     c_src1   <= o_src1;
                     c_src2   <= o_src2;
                     c_sgn    <= o_sgn;
                     c_quo    <= quo_fix;
                     c_rem    <= rem_fix;
`endif
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               S_DONE: begin
                  // start is ignored here: the requesting instruction is leaving EX.
                  state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
